// File: rtl/ula_multiciclo.sv
// Handshaked multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative SHL/SHR/MUL.
// Results and flags are registered and held while the consumer stalls.
//
// state | meaning
// IDLE  | waiting for a request (in_ready high once out of reset)
// RUN   | iterating a shift or multiply, one step per cycle
// DONE  | result presented, waiting for out_ready
module ula_multiciclo #(
  parameter  int WIDTH = 16,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam int CNT_W = SH_W + 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic               armed_q;
  logic [3:0]         op_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   s_q;
  logic               z_q, n_q, c_q, v_q, err_q;

  logic [SH_W-1:0]    k;
  logic [WIDTH:0]     add_w;
  logic [WIDTH-1:0]   alu_s;
  logic               alu_c, alu_v, alu_err, alu_z;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] run_p;
  logic               run_c;
  logic [WIDTH-1:0]   run_s;

  assign k = b[SH_W-1:0];

  always_comb begin
    add_w   = '0;
    alu_s   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD: begin
        add_w = {1'b0, a} + {1'b0, b};
        alu_s = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        add_w = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        alu_s = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_s = a & b;
      OP_OR:  alu_s = a | b;
      OP_XOR: alu_s = a ^ b;
      // Zero-amount shifts complete here; nonzero amounts and MUL go through RUN.
      OP_SHL, OP_SHR: alu_s = a;
      OP_MUL: alu_s = '0;
      default: alu_err = 1'b1;
    endcase
    alu_z = (alu_s == '0) && !alu_err;
  end

  // One iteration step; for MUL p_q holds {partial_high, remaining_multiplier}.
  always_comb begin
    mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : '0);
    run_p   = p_q;
    run_c   = 1'b0;
    case (op_q)
      OP_SHL: begin
        run_p[WIDTH-1:0] = {p_q[WIDTH-2:0], 1'b0};
        run_c            = p_q[WIDTH-1];
      end
      OP_SHR: begin
        run_p[WIDTH-1:0] = {1'b0, p_q[WIDTH-1:1]};
        run_c            = p_q[0];
      end
      default: begin
        run_p = {mul_sum, p_q[WIDTH-1:1]};
        run_c = |run_p[2*WIDTH-1:WIDTH];
      end
    endcase
    run_s = run_p[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      op_q    <= '0;
      p_q     <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q <= op;
            if ((op == OP_SHL || op == OP_SHR) && (k != '0)) begin
              state_q <= RUN;
              p_q     <= {{WIDTH{1'b0}}, a};
              cnt_q   <= {1'b0, k};
            end else if (op == OP_MUL) begin
              state_q <= RUN;
              p_q     <= {{WIDTH{1'b0}}, b};
              mcand_q <= a;
              cnt_q   <= CNT_W'(WIDTH);
            end else begin
              state_q <= DONE;
              s_q     <= alu_s;
              z_q     <= alu_z;
              n_q     <= alu_s[WIDTH-1];
              c_q     <= alu_c;
              v_q     <= alu_v;
              err_q   <= alu_err;
            end
          end
        end
        RUN: begin
          p_q   <= run_p;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            s_q     <= run_s;
            z_q     <= (run_s == '0);
            n_q     <= run_s[WIDTH-1];
            c_q     <= run_c;
            v_q     <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = armed_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo (WIDTH=16): directed corner cases plus
// random operations checked against an arithmetic reference model.
module tb_ula_multiciclo;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = 4'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  s;
  logic          flag_z, flag_n, flag_c, flag_v, err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] s;
    logic z, n, c, v, e;
    int   lat;
  } res_t;

  ula_multiciclo #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .err(err)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [3:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
    res_t   r;
    longint ua, ub, full;
    int     sa, sb, sr, k;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    k  = int'(mb[3:0]);
    r.s = '0; r.c = 1'b0; r.v = 1'b0; r.e = 1'b0; r.lat = 1;
    case (mop)
      4'd0: begin
        full = ua + ub; r.s = full[W-1:0]; r.c = (full > 65535);
        sr = sa + sb;   r.v = (sr > 32767) || (sr < -32768);
      end
      4'd1: begin
        full = ua - ub; r.s = full[W-1:0]; r.c = (ua >= ub);
        sr = sa - sb;   r.v = (sr > 32767) || (sr < -32768);
      end
      4'd2: r.s = ma & mb;
      4'd3: r.s = ma | mb;
      4'd4: r.s = ma ^ mb;
      4'd5: begin
        full = ua << k; r.s = full[W-1:0];
        r.c = (k > 0) ? full[W] : 1'b0;
        r.lat = k + 1;
      end
      4'd6: begin
        full = ua >> k; r.s = full[W-1:0];
        r.c = (k > 0) ? ((ua >> (k - 1)) % 2 == 1) : 1'b0;
        r.lat = k + 1;
      end
      4'd7: begin
        full = ua * ub; r.s = full[W-1:0];
        r.c = (full / 65536) != 0;
        r.lat = W + 1;
      end
      default: r.e = 1'b1;
    endcase
    r.z = (r.s == '0) && !r.e;
    r.n = r.s[W-1];
    return r;
  endfunction

  // Issue one request and wait for its result; leaves the result unreleased.
  task automatic issue(input logic [3:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       output res_t obs);
    int guard;
    guard = 0;
    obs.lat = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_in_ready: in_ready=%0b required 1 within 50 cycles", in_ready);
    end
    in_valid = 1'b1; op = iop; a = ia; b = ib;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); op = 4'($urandom);
    guard = 0;
    do begin
      @(negedge clk);
      obs.lat++;
    end while (!out_valid && obs.lat < 40);
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_out_valid: out_valid=%0b required 1 within 40 cycles", out_valid);
    end
    obs.s = s; obs.z = flag_z; obs.n = flag_n; obs.c = flag_c; obs.v = flag_v; obs.e = err;
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, s, flag_z, flag_n, flag_c, flag_v, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%0b ov=%0b s=%h zncv=%0b%0b%0b%0b err=%0b required all 0",
               in_ready, out_valid, s, flag_z, flag_n, flag_c, flag_v, err);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_release_ready: in_ready=%0b required 0 before first edge", in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_first_edge_ready: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_add_sub();
    res_t o;
    issue(4'd0, 16'h7FFF, 16'h0001, o);
    n_cmp++;
    if ({o.s, o.z, o.n, o.c, o.v, o.e, o.lat} !== {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1}) begin
      n_bad++; $display("FAIL add_overflow: s=%h zncv=%0b%0b%0b%0b err=%0b lat=%0d required s=8000 zncv=0101 err=0 lat=1",
                        o.s, o.z, o.n, o.c, o.v, o.e, o.lat);
    end
    release_out();
    issue(4'd1, 16'h0000, 16'h0001, o);
    n_cmp++;
    if ({o.s, o.c, o.n, o.v, o.z} !== {16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL sub_wrap: s=%h c=%0b n=%0b v=%0b z=%0b required s=ffff c=0 n=1 v=0 z=0",
                        o.s, o.c, o.n, o.v, o.z);
    end
    release_out();
    issue(4'd1, 16'h1234, 16'h1234, o);
    n_cmp++;
    if ({o.s, o.z, o.c, o.n, o.v} !== {16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL sub_equal: s=%h z=%0b c=%0b n=%0b v=%0b required s=0000 z=1 c=1 n=0 v=0",
                        o.s, o.z, o.c, o.n, o.v);
    end
    release_out();
    issue(4'd0, 16'hFFFF, 16'h0003, o);
    n_cmp++;
    if ({o.s, o.c, o.v} !== {16'h0002, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL add_carry: s=%h c=%0b v=%0b required s=0002 c=1 v=0", o.s, o.c, o.v);
    end
    // Leave a nonzero held result so the mid-MUL reset has something to clear.
    issue_leave_nonzero();
  endtask

  task automatic issue_leave_nonzero();
    release_out();
  endtask

  task automatic test_reset_mid_mul();
    res_t o;
    int   guard;
    issue(4'd2, 16'hF0F0, 16'hFFFF, o);
    release_out();
    @(negedge clk);
    in_valid = 1'b1; op = 4'd7; a = 16'd3; b = 16'd5;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, s, flag_z, flag_n, flag_c, flag_v, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_mul_outputs: rdy=%0b ov=%0b s=%h zncv=%0b%0b%0b%0b err=%0b required all 0",
               in_ready, out_valid, s, flag_z, flag_n, flag_c, flag_v, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid_mul_ready: in_ready=%0b required 1", in_ready);
    end
    guard = 0;
    repeat (24) begin
      @(negedge clk);
      if (out_valid !== 1'b0) guard++;
    end
    n_cmp++;
    if (guard != 0) begin
      n_bad++; $display("FAIL reset_mid_mul_no_result: out_valid high %0d cycles required 0", guard);
    end
  endtask

  task automatic test_shift_mul();
    res_t o;
    issue(4'd5, 16'h8001, 16'h0011, o);
    n_cmp++;
    if ({o.s, o.c, o.lat} !== {16'h0002, 1'b1, 32'd2}) begin
      n_bad++; $display("FAIL shl_k1: s=%h c=%0b lat=%0d required s=0002 c=1 lat=2", o.s, o.c, o.lat);
    end
    release_out();
    issue(4'd6, 16'h00F0, 16'h0000, o);
    n_cmp++;
    if ({o.s, o.c, o.lat} !== {16'h00F0, 1'b0, 32'd1}) begin
      n_bad++; $display("FAIL shr_k0: s=%h c=%0b lat=%0d required s=00f0 c=0 lat=1", o.s, o.c, o.lat);
    end
    release_out();
    issue(4'd6, 16'h0001, 16'h000F, o);
    n_cmp++;
    if ({o.s, o.z, o.c, o.lat} !== {16'h0000, 1'b1, 1'b0, 32'd16}) begin
      n_bad++; $display("FAIL shr_k15: s=%h z=%0b c=%0b lat=%0d required s=0000 z=1 c=0 lat=16", o.s, o.z, o.c, o.lat);
    end
    release_out();
    issue(4'd7, 16'h0100, 16'h0100, o);
    n_cmp++;
    if ({o.s, o.z, o.c, o.lat} !== {16'h0000, 1'b1, 1'b1, 32'd17}) begin
      n_bad++; $display("FAIL mul_overflow: s=%h z=%0b c=%0b lat=%0d required s=0000 z=1 c=1 lat=17", o.s, o.z, o.c, o.lat);
    end
    release_out();
    issue(4'd7, 16'd300, 16'd200, o);
    n_cmp++;
    if ({o.s, o.c, o.v, o.z} !== {16'hEA60, 1'b0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL mul_300x200: s=%h c=%0b v=%0b z=%0b required s=ea60 c=0 v=0 z=0", o.s, o.c, o.v, o.z);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    res_t o;
    int   bad;
    issue(4'd4, 16'hFF00, 16'h0FF0, o);
    bad = 0;
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (s !== 16'hF0F0 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL xor_hold: %0d stalled cycles wrong (s=%h rdy=%0b ov=%0b) required s=f0f0 rdy=0 ov=1",
                        bad, s, in_ready, out_valid);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, s} !== {1'b0, 1'b1, 16'hF0F0}) begin
      n_bad++; $display("FAIL xor_release: ov=%0b rdy=%0b s=%h required ov=0 rdy=1 s=f0f0", out_valid, in_ready, s);
    end
    issue(4'b1010, 16'h1234, 16'h5678, o);
    n_cmp++;
    if ({o.s, o.e, o.z, o.n, o.c, o.v, o.lat} !== {16'h0000, 1'b1, 4'b0000, 32'd1}) begin
      n_bad++; $display("FAIL illegal_op: s=%h err=%0b zncv=%0b%0b%0b%0b lat=%0d required s=0000 err=1 zncv=0000 lat=1",
                        o.s, o.e, o.z, o.n, o.c, o.v, o.lat);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    res_t exp;
    int   ones;
    logic [W-1:0] last_s;
    exp = model(4'd0, 16'h1111, 16'h2222);
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0; a = 16'h1111; b = 16'h2222; out_ready = 1'b1;
    ones = 0;
    last_s = '0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) begin ones++; last_s = s; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (ones != 10) begin
      n_bad++; $display("FAIL back_to_back_rate: %0d results in 20 cycles required 10", ones);
    end
    n_cmp++;
    if (last_s !== exp.s) begin
      n_bad++; $display("FAIL back_to_back_value: s=%h required %h", last_s, exp.s);
    end
    @(negedge clk);
    if (out_valid) release_out();
  endtask

  task automatic test_random();
    res_t o, e;
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 80; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = W'($urandom);
      e   = model(rop, ra, rb);
      issue(rop, ra, rb, o);
      n_cmp++;
      if ({o.s, o.z, o.n, o.c, o.v, o.e} !== {e.s, e.z, e.n, e.c, e.v, e.e}) begin
        n_bad++; $display("FAIL random_result op=%h a=%h b=%h: s=%h zncve=%0b%0b%0b%0b%0b required s=%h zncve=%0b%0b%0b%0b%0b",
                          rop, ra, rb, o.s, o.z, o.n, o.c, o.v, o.e, e.s, e.z, e.n, e.c, e.v, e.e);
      end
      n_cmp++;
      if (o.lat != e.lat) begin
        n_bad++; $display("FAIL random_latency op=%h b=%h: lat=%0d required %0d", rop, rb, o.lat, e.lat);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_reset_mid_mul();
    test_shift_mul();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
Parametrised, handshaked successor to the processor's 16-bit combinational ALU. Keeps the ADD/SUB/AND/OR/XOR opcode encoding. Adds:
- registered outputs and status flags;
- valid/ready handshakes on input and output;
- iterative multi-cycle SHL, SHR and MUL.
Sits between the register-file read stage and write-back. Controller stalls on in_ready/out_valid.

Parameters:
WIDTH, 16, operand/result width in bits (>=4, power of two)
SH_W, $clog2(WIDTH), derived; shift-amount field width, not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request
op  input  4  opcode
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result available
out_ready  input  1  consumer takes result
s  output  WIDTH  result
flag_z  output  1  s == 0
flag_n  output  1  s[WIDTH-1]
flag_c  output  1  carry / shift-out / MUL overflow, per op
flag_v  output  1  signed overflow (ADD/SUB only)
err  output  1  illegal opcode

Behaviour:
- Reset: asynchronous active-low. All outputs 0, in_ready=0 while rst_n low. FSM returns to IDLE with all internal registers cleared, including mid-operation. in_ready=1 from the first clock edge after release.
- FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept: in_valid & in_ready at a clock edge. op/a/b are captured. a and b may change afterwards without effect.
- Opcodes 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR:
  - single cycle: IDLE -> DONE on the accept edge;
  - out_valid is high the cycle after accept (latency 1).
- 0101 SHL, 0110 SHR (logical, zero fill):
  - shift amount k = b[SH_W-1:0]; upper bits of b are ignored;
  - IDLE -> RUN with down-counter = k; one bit shifted per cycle in RUN;
  - RUN -> DONE when counter reaches 0, so latency k+1;
  - k=0 goes directly IDLE -> DONE with s=a, latency 1.
- 0111 MUL:
  - unsigned shift-add, one multiplier bit per cycle, WIDTH iterations;
  - latency WIDTH+1; s = low WIDTH bits of the product.
- 1000-1111: IDLE -> DONE, latency 1, s=0, err=1, all other flags 0.
- Arithmetic rules:
  - ADD: s = (a+b) mod 2^WIDTH; C = carry out of MSB.
  - SUB: s = a + ~b + 1; C = carry out of MSB (1 when a >= b unsigned, i.e. no borrow).
  - V = signed overflow for ADD/SUB (operand signs equal, or differ for SUB, and result sign differs); V=0 for all other ops.
  - SHL/SHR: C = last bit shifted out; C=0 when k=0.
  - MUL: C=1 if any bit of the high WIDTH product bits is nonzero.
  - AND/OR/XOR: C=0.
  - Z and N always computed from final s. err=0 for legal ops.
- Output hold: s, flags and err are stable throughout DONE. They change only on a new accept or on reset.
- DONE -> IDLE when out_ready=1. in_ready rises the following cycle; there is no same-cycle accept on release.
- out_ready high before DONE has no effect. in_valid during RUN/DONE is ignored; the requester must hold it.
- Throughput: at most one op in flight. Single-cycle ops sustain 1 op / 2 cycles with out_ready tied high.

Test Plan:
- Reset mid-MUL: WIDTH=16, a=3, b=5 MUL accepted; rst_n low 4 cycles later -> all outputs 0 immediately, in_ready=1 one cycle after release, no out_valid.
- ADD overflow: a=0x7FFF, b=0x0001 -> s=0x8000, N=1, V=1, C=0, Z=0, out_valid the cycle after accept.
- SUB wrap: a=0x0000, b=0x0001 -> s=0xFFFF, C=0, N=1, V=0. Then a=b=0x1234 SUB -> s=0, Z=1, C=1.
- Shifts: SHL a=0x8001, b=0x0011 (k=1) -> s=0x0002, C=1, latency 2. SHR a=0x00F0, k=0 -> s=0x00F0, C=0, latency 1. SHR a=0x0001, k=15 -> s=0, Z=1, C=0, latency 16.
- MUL: a=0x0100, b=0x0100 -> s=0x0000, Z=1, C=1, latency 17. a=300, b=200 -> s=0xEA60, C=0.
- Backpressure/illegal: XOR a=0xFF00, b=0x0FF0 with out_ready low 5 cycles -> s=0xF0F0 held and in_ready=0 throughout; op=1010 -> s=0, err=1.
